// File: rtl/fetch_btb.sv
// fetch_btb: fetch-stage PC generator with a direct-mapped branch target
// buffer and 2-bit saturating direction counters.
//
// Optional feature macro: BTB_EN. When defined, the BTB, the predictors and
// the delay-slot (SLOT) state are built. When undefined, the block is a plain
// PC generator (except / redirect, buffered across stalls, else pc+4) and the
// prediction outputs are tied to zero.
//
// Next-PC priority on an unstalled edge: except, redirect, pending SLOT
// target, predicted-taken (fetch the delay slot first), pc+4.
//
// Redirect buffer: requests seen while stalled are folded into one pending
// {kind, pc} entry (kind 1 = except, 0 = redirect). An except is replaced
// only by a newer except; a redirect is replaced by anything newer. It is
// applied and cleared on the first unstalled edge, where a live request wins
// only if its kind is equal or higher.
//
// No extra handshakes: all requests are single-cycle level pulses sampled at
// the rising edge; the block never back-pressures its requesters.
module fetch_btb #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic [31:0] pcF_o,
  output logic        pc_adel_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        except_i,
  input  logic [31:0] except_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] pc_plus4;

  // pending redirect/except captured during a stall
  logic        buf_valid;
  logic        buf_kind;
  logic [31:0] buf_pc;

  // resolved correction for this edge (live or buffered)
  logic        fix_valid;
  logic [31:0] fix_pc;

  assign pc_plus4  = pc + 32'd4;
  assign pcF_o     = pc;
  assign pc_adel_o = |pc[1:0];

  // Pick the winning correction: live except, buffered except, live redirect,
  // buffered redirect.
  always_comb begin
    fix_valid = 1'b1;
    fix_pc    = except_pc_i;
    if (except_i) begin
      fix_pc = except_pc_i;
    end else if (buf_valid && buf_kind) begin
      fix_pc = buf_pc;
    end else if (redirect_i) begin
      fix_pc = redirect_pc_i;
    end else if (buf_valid) begin
      fix_pc = buf_pc;
    end else begin
      fix_valid = 1'b0;
      fix_pc    = '0;
    end
  end

  // Capture requests while stalled; drop the buffer on the first free edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_kind  <= 1'b0;
      buf_pc    <= '0;
    end else if (stall_i) begin
      if (except_i) begin
        buf_valid <= 1'b1;
        buf_kind  <= 1'b1;
        buf_pc    <= except_pc_i;
      end else if (redirect_i && !(buf_valid && buf_kind)) begin
        buf_valid <= 1'b1;
        buf_kind  <= 1'b0;
        buf_pc    <= redirect_pc_i;
      end
    end else begin
      buf_valid <= 1'b0;
      buf_kind  <= 1'b0;
      buf_pc    <= '0;
    end
  end

  // PC register; pc_nx already holds the value when stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nx;
    end
  end

`ifdef BTB_EN

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {
    NORMAL = 1'b0,
    SLOT   = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] slot_tgt;
  logic [31:0] slot_tgt_nx;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // low PC bits of an update never matter for indexing or tagging
  wire unused_upd_lsb = ^upd_pc_i[1:0];

  assign look_idx = pc[IDX_W+1:2];
  assign look_tag = pc[31:IDX_W+2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign pred_taken_o  = look_hit && ctr_q[look_idx][1];
  assign pred_target_o = look_hit ? tgt_q[look_idx] : 32'd0;

  // Valid bits are the only reset array state; allocate on a taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_valid_i && !upd_hit && upd_taken_i) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/target/counter arrays: train on hits, allocate on taken misses.
  always_ff @(posedge clk) begin
    if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
          end
          tgt_q[upd_idx] <= upd_target_i;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        tag_q[upd_idx] <= upd_tag;
        tgt_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx] <= 2'b10;
      end
    end
  end

  // Fetch FSM state register and latched delay-slot target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= NORMAL;
      slot_tgt <= '0;
    end else begin
      state    <= state_nx;
      slot_tgt <= slot_tgt_nx;
    end
  end

  // Next PC / next state in priority order; everything holds when stalled.
  always_comb begin
    pc_nx       = pc;
    state_nx    = state;
    slot_tgt_nx = slot_tgt;
    if (!stall_i) begin
      if (fix_valid) begin
        pc_nx       = fix_pc;
        state_nx    = NORMAL;
        slot_tgt_nx = '0;
      end else if (state == SLOT) begin
        pc_nx       = slot_tgt;
        state_nx    = NORMAL;
        slot_tgt_nx = '0;
      end else if (pred_taken_o) begin
        pc_nx       = pc_plus4;
        state_nx    = SLOT;
        slot_tgt_nx = pred_target_o;
      end else begin
        pc_nx = pc_plus4;
      end
    end
  end

`else

  // without a BTB the update port has no consumer
  wire unused_upd = ^{upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i};

  assign pred_taken_o  = 1'b0;
  assign pred_target_o = 32'd0;

  // Next PC: correction if any, else pc+4; hold when stalled.
  always_comb begin
    pc_nx = pc;
    if (!stall_i) begin
      pc_nx = fix_valid ? fix_pc : pc_plus4;
    end
  end

`endif

endmodule

// File: tb/tb_fetch_btb.sv
// tb_fetch_btb: vector table plus hand-written sequences for fetch_btb.
// BTB-specific sequences are built only when BTB_EN is defined.
module tb_fetch_btb;

  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic [31:0] pcF_o;
  logic        pc_adel_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        except_i;
  logic [31:0] except_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;

  int checks;
  int failures;

  typedef struct {
    logic        stall;
    logic        red;
    logic [31:0] rpc;
    logic        exc;
    logic [31:0] epc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] exp_pc;
    logic        exp_pred;
    logic [31:0] exp_tgt;
  } vec_t;

  // {pred, target, pc} expected after the edge being driven
  logic [64:0] exp_q[$];

  vec_t tbl[29];

  fetch_btb #(
    .ENTRIES (4),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .pcF_o        (pcF_o),
    .pc_adel_o    (pc_adel_o),
    .pred_taken_o (pred_taken_o),
    .pred_target_o(pred_target_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .except_i     (except_i),
    .except_pc_i  (except_pc_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic e, input logic [31:0] epc,
                              input logic [31:0] exp_pc, input logic exp_pred,
                              input logic [31:0] exp_tgt);
    vec_t v;
    v.stall = s; v.red = r; v.rpc = rpc; v.exc = e; v.epc = epc;
    v.uv = 1'b0; v.upc = '0; v.ut = 1'b0; v.utgt = '0;
    v.exp_pc = exp_pc; v.exp_pred = exp_pred; v.exp_tgt = exp_tgt;
    return v;
  endfunction

  function automatic vec_t with_upd(input vec_t b, input logic [31:0] upc,
                                    input logic ut, input logic [31:0] utgt);
    vec_t v;
    v = b;
    v.uv = 1'b1; v.upc = upc; v.ut = ut; v.utgt = utgt;
    return v;
  endfunction

  // compare the DUT outputs against the oldest expected record
  task automatic compare(input string tag);
    logic [64:0] e;
    logic [31:0] e_adel;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue: act=empty exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      e_adel = {31'd0, |e[1:0]};
      check({tag, "_pc"}, pcF_o, e[31:0]);
      check({tag, "_pred"}, {31'd0, pred_taken_o}, {31'd0, e[64]});
      check({tag, "_tgt"}, pred_target_o, e[63:32]);
      check({tag, "_adel"}, {31'd0, pc_adel_o}, e_adel);
    end
  endtask

  // drive one cycle of stimulus (called just after a rising edge)
  task automatic step(input vec_t v, input string tag);
    stall_i       = v.stall;
    redirect_i    = v.red;
    redirect_pc_i = v.rpc;
    except_i      = v.exc;
    except_pc_i   = v.epc;
    upd_valid_i   = v.uv;
    upd_pc_i      = v.upc;
    upd_taken_i   = v.ut;
    upd_target_i  = v.utgt;
    exp_q.push_back({v.exp_pred, v.exp_tgt, v.exp_pc});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // row: stall, redirect, rpc, except, epc -> pc after edge, pred, target
    tbl[0]  = mk(0, 0, 0, 0, 0, 32'hbfc00004, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'hbfc00008, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'hbfc0000c, 0, 0);
    tbl[3]  = mk(0, 1, 32'h00001000, 0, 0, 32'h00001000, 0, 0);
    tbl[4]  = mk(0, 1, 32'h00003000, 1, 32'h00002000, 32'h00002000, 0, 0);
    tbl[5]  = mk(1, 1, 32'hbfc00200, 0, 0, 32'h00002000, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 32'hbfc00380, 32'h00002000, 0, 0);
    tbl[7]  = mk(1, 1, 32'hbfc00400, 0, 0, 32'h00002000, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 32'h00002000, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 32'hbfc00380, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'hbfc00384, 0, 0);
    tbl[11] = mk(1, 1, 32'h00000500, 0, 0, 32'hbfc00384, 0, 0);
    tbl[12] = mk(0, 1, 32'h00000600, 0, 0, 32'h00000600, 0, 0);
    tbl[13] = mk(1, 0, 0, 1, 32'h00000700, 32'h00000600, 0, 0);
    tbl[14] = mk(0, 1, 32'h00000800, 0, 0, 32'h00000700, 0, 0);
    tbl[15] = mk(1, 1, 32'h00000900, 0, 0, 32'h00000700, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 32'h00000a00, 32'h00000a00, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 32'h00000a04, 0, 0);
    tbl[18] = mk(1, 0, 0, 1, 32'h00000b00, 32'h00000a04, 0, 0);
    tbl[19] = mk(0, 0, 0, 1, 32'h00000c00, 32'h00000c00, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 32'h00000c04, 0, 0);
    tbl[21] = mk(1, 0, 0, 1, 32'h00000d00, 32'h00000c04, 0, 0);
    tbl[22] = mk(1, 0, 0, 1, 32'h00000e00, 32'h00000c04, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 32'h00000e00, 0, 0);
    tbl[24] = mk(0, 1, 32'hfffffff8, 0, 0, 32'hfffffff8, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 32'hfffffffc, 0, 0);
    tbl[26] = mk(0, 0, 0, 0, 0, 32'h00000000, 0, 0);
    tbl[27] = mk(0, 1, 32'h00000002, 0, 0, 32'h00000002, 0, 0);
    tbl[28] = mk(0, 1, 32'h00000020, 0, 0, 32'h00000020, 0, 0);

    // reset block
    rst = 1'b1;
    stall_i = 0; redirect_i = 0; redirect_pc_i = 0; except_i = 0; except_pc_i = 0;
    upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({1'b0, 32'd0, RST_PC});
    compare("reset");

    for (int i = 0; i < 29; i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // reset with a non-empty redirect buffer discards it
    step(mk(1, 1, 32'h00000700, 0, 0, 32'h00000020, 0, 0), "rstbuf_fill");
    rst = 1'b1;
    #2;
    exp_q.push_back({1'b0, 32'd0, RST_PC});
    compare("rstbuf_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 0, 32'hbfc00004, 0, 0), "rstbuf_after");

`ifndef BTB_EN
    // update port has no effect without a BTB
    step(with_upd(mk(0, 1, 32'h00000024, 0, 0, 32'h00000024, 0, 0),
                  32'h00000024, 1, 32'h00000500), "noBtb_upd0");
    step(with_upd(mk(0, 0, 0, 0, 0, 32'h00000028, 0, 0),
                  32'h00000028, 1, 32'h00000600), "noBtb_upd1");
    step(mk(0, 1, 32'h00000024, 0, 0, 32'h00000024, 0, 0), "noBtb_again");
    step(mk(0, 0, 0, 0, 0, 32'h00000028, 0, 0), "noBtb_fall");
    step(mk(0, 0, 0, 0, 0, 32'h0000002c, 0, 0), "noBtb_fall2");
`else
    // allocate bfc00010 -> bfc00100, then fetch through branch, slot, target
    step(with_upd(mk(0, 0, 0, 0, 0, 32'hbfc00008, 0, 0),
                  32'hbfc00010, 1, 32'hbfc00100), "alloc");
    step(mk(0, 0, 0, 0, 0, 32'hbfc0000c, 0, 0), "a_c");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00010, 1, 32'hbfc00100), "a_branch");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "a_slot");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00100, 0, 0), "a_target");

    // stalls around the branch and in the slot do not lose SLOT
    step(mk(0, 1, 32'hbfc00010, 0, 0, 32'hbfc00010, 1, 32'hbfc00100), "s_branch");
    step(mk(1, 0, 0, 0, 0, 32'hbfc00010, 1, 32'hbfc00100), "s_hold0");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "s_slot");
    step(mk(1, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "s_hold1");
    step(mk(1, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "s_hold2");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00100, 0, 0), "s_target");

    // two not-taken updates: counter 2 -> 1 -> 0, branch now falls through
    step(with_upd(mk(0, 0, 0, 0, 0, 32'hbfc00104, 0, 0),
                  32'hbfc00010, 0, 32'h0), "nt1");
    step(with_upd(mk(0, 0, 0, 0, 0, 32'hbfc00108, 0, 0),
                  32'hbfc00010, 0, 32'h0), "nt2");
    step(mk(0, 1, 32'hbfc00010, 0, 0, 32'hbfc00010, 0, 32'hbfc00100), "nt_branch");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "nt_next");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00018, 0, 0), "nt_fall");

    // retrain 0 -> 1 -> 2, then except in the slot cycle kills the target
    step(with_upd(mk(0, 0, 0, 0, 0, 32'hbfc0001c, 0, 0),
                  32'hbfc00010, 1, 32'hbfc00100), "t1");
    step(with_upd(mk(0, 0, 0, 0, 0, 32'hbfc00020, 0, 0),
                  32'hbfc00010, 1, 32'hbfc00100), "t2");
    step(mk(0, 1, 32'hbfc00010, 0, 0, 32'hbfc00010, 1, 32'hbfc00100), "x_branch");
    step(mk(0, 0, 0, 0, 0, 32'hbfc00014, 0, 0), "x_slot");
    step(mk(0, 0, 0, 1, 32'h80000180, 32'h80000180, 0, 0), "x_except");
    step(mk(0, 0, 0, 0, 0, 32'h80000184, 0, 0), "x_after");

    // aliasing on index 0: 00000050 replaces 00000010
    step(with_upd(mk(0, 0, 0, 0, 0, 32'h80000188, 0, 0),
                  32'h00000010, 1, 32'h00000300), "al_a");
    step(with_upd(mk(0, 0, 0, 0, 0, 32'h8000018c, 0, 0),
                  32'h00000050, 1, 32'h00000400), "al_b");
    step(mk(0, 1, 32'h00000010, 0, 0, 32'h00000010, 0, 0), "al_miss");
    step(mk(0, 1, 32'h00000050, 0, 0, 32'h00000050, 1, 32'h00000400), "al_hit");
    step(mk(0, 0, 0, 0, 0, 32'h00000054, 0, 0), "al_slot");
    step(mk(0, 0, 0, 0, 0, 32'h00000400, 0, 0), "al_target");

    // reset while in SLOT clears state and BTB valid bits
    step(mk(0, 1, 32'h00000050, 0, 0, 32'h00000050, 1, 32'h00000400), "rs_branch");
    step(mk(0, 0, 0, 0, 0, 32'h00000054, 0, 0), "rs_slot");
    rst = 1'b1;
    #2;
    exp_q.push_back({1'b0, 32'd0, RST_PC});
    compare("rs_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 0, 32'hbfc00004, 0, 0), "rs_after");
    step(mk(0, 1, 32'h00000050, 0, 0, 32'h00000050, 0, 0), "rs_invalid");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
